// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush, bubble-masked control and a saturating stall counter.
module id_ex_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 70,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic              in_fire;
    logic              out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_v;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            // in_ready comes straight from the skid flop, so decode never sees
            // a combinational path back from execute.
            assign in_ready   = !skid_v;
            assign skid_valid = skid_v;

            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    main_data  <= '0;
                    skid_v     <= 1'b0;
                    skid_ctrl  <= '0;
                    skid_data  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    skid_v     <= 1'b0;
                    skid_ctrl  <= '0;
                end else if (!main_valid) begin
                    if (in_fire) begin
                        main_valid <= 1'b1;
                        main_ctrl  <= in_ctrl;
                        main_data  <= in_data;
                    end
                end else if (out_fire) begin
                    if (skid_v) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_v    <= 1'b0;
                        skid_ctrl <= '0;
                    end else if (in_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else begin
                        main_valid <= 1'b0;
                        main_ctrl  <= '0;
                    end
                end else if (in_fire) begin
                    skid_v    <= 1'b1;
                    skid_ctrl <= in_ctrl;
                    skid_data <= in_data;
                end
            end
        end else begin : g_noskid
            assign in_ready   = out_ready | !main_valid;
            assign skid_valid = 1'b0;

            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    main_data  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end else if (in_fire) begin
                    main_valid <= 1'b1;
                    main_ctrl  <= in_ctrl;
                    main_data  <= in_data;
                end else if (out_fire) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end
            end
        end
    endgenerate

    // Performance counter: deliberately ignores flush so stalls survive a redirect.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg: a SKID=1/CNT_W=4 instance and a
// SKID=0 instance driven from hand-computed vectors.
module tb_id_ex_stage_reg;

    logic        clk = 1'b1;
    logic        rst_n;
    logic        flush;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [8:0]  a_in_ctrl, a_out_ctrl;
    logic [69:0] a_in_data, a_out_data;
    logic [1:0]  a_occupancy;
    logic [3:0]  a_stall_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [8:0]  b_in_ctrl, b_out_ctrl;
    logic [69:0] b_in_data, b_out_data;
    logic [1:0]  b_occupancy;
    logic [15:0] b_stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.CTRL_W(9), .DATA_W(70), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occupancy), .stall_cnt(a_stall_cnt)
    );

    id_ex_stage_reg #(.CTRL_W(9), .DATA_W(70), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [8:0] ctrl,
                                 input logic [69:0] data, input logic ready);
        a_in_valid  = valid;
        a_in_ctrl   = ctrl;
        a_in_data   = data;
        a_out_ready = ready;
    endtask

    // Wait through one falling (active) edge and settle before sampling.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 9'h0, 70'h0, 1'b0);
        b_in_valid = 1'b0; b_in_ctrl = 9'h0; b_in_data = 70'h0; b_out_ready = 1'b0;

        #1;
        checkOutput("rst_out_valid", 128'(a_out_valid), 128'd0);
        checkOutput("rst_out_ctrl", 128'(a_out_ctrl), 128'd0);
        checkOutput("rst_out_data", 128'(a_out_data), 128'd0);
        checkOutput("rst_occupancy", 128'(a_occupancy), 128'd0);
        checkOutput("rst_stall_cnt", 128'(a_stall_cnt), 128'd0);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 128'(a_in_ready), 128'd1);
        checkOutput("rst_b_in_ready", 128'(b_in_ready), 128'd1);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 9'(i), 70'(i), 1'b1);
            tick();
            checkOutput($sformatf("stream_data_%0d", i), 128'(a_out_data), 128'(i));
            checkOutput($sformatf("stream_ctrl_%0d", i), 128'(a_out_ctrl), 128'(i));
            checkOutput($sformatf("stream_ready_%0d", i), 128'(a_in_ready), 128'd1);
        end
        checkOutput("stream_stall_cnt", 128'(a_stall_cnt), 128'd0);

        // Bubble masking after a regWrite entry drains
        applyStimulus(1'b1, 9'h020, 70'h99, 1'b1);
        tick();
        checkOutput("bubble_ctrl_live", 128'(a_out_ctrl), 128'h020);
        applyStimulus(1'b0, 9'h1FF, 70'h0, 1'b1);
        tick();
        checkOutput("bubble_out_valid", 128'(a_out_valid), 128'd0);
        checkOutput("bubble_out_ctrl", 128'(a_out_ctrl), 128'd0);
        checkOutput("bubble_occupancy", 128'(a_occupancy), 128'd0);

        // Backpressure fills the skid, then drains in order
        applyStimulus(1'b1, 9'h001, 70'hA, 1'b0);
        tick();
        checkOutput("bp_occ_1", 128'(a_occupancy), 128'd1);
        applyStimulus(1'b1, 9'h002, 70'hB, 1'b0);
        tick();
        checkOutput("bp_occ_2", 128'(a_occupancy), 128'd2);
        checkOutput("bp_in_ready", 128'(a_in_ready), 128'd0);
        checkOutput("bp_stall_0", 128'(a_stall_cnt), 128'd0);
        applyStimulus(1'b1, 9'h003, 70'hC, 1'b0);
        tick();
        checkOutput("bp_stall_1", 128'(a_stall_cnt), 128'd1);
        tick();
        checkOutput("bp_stall_2", 128'(a_stall_cnt), 128'd2);
        checkOutput("bp_head_A", 128'(a_out_data), 128'hA);
        applyStimulus(1'b1, 9'h003, 70'hC, 1'b1);
        tick();
        checkOutput("bp_head_B", 128'(a_out_data), 128'hB);
        checkOutput("bp_stall_3", 128'(a_stall_cnt), 128'd3);
        checkOutput("bp_ready_back", 128'(a_in_ready), 128'd1);
        tick();
        checkOutput("bp_head_C", 128'(a_out_data), 128'hC);
        checkOutput("bp_head_C_valid", 128'(a_out_valid), 128'd1);
        applyStimulus(1'b0, 9'h0, 70'h0, 1'b1);
        tick();
        checkOutput("bp_drained", 128'(a_out_valid), 128'd0);

        // Flush with both slots full and an incoming entry
        applyStimulus(1'b1, 9'h1FF, 70'h11, 1'b0);
        tick();
        applyStimulus(1'b1, 9'h1FF, 70'h22, 1'b0);
        tick();
        checkOutput("fl_occ_full", 128'(a_occupancy), 128'd2);
        checkOutput("fl_ctrl_full", 128'(a_out_ctrl), 128'h1FF);
        applyStimulus(1'b1, 9'h1FF, 70'h33, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fl_occupancy", 128'(a_occupancy), 128'd0);
        checkOutput("fl_out_valid", 128'(a_out_valid), 128'd0);
        checkOutput("fl_out_ctrl", 128'(a_out_ctrl), 128'd0);
        checkOutput("fl_in_ready", 128'(a_in_ready), 128'd1);
        applyStimulus(1'b1, 9'h1FF, 70'h44, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fl_fire_discard", 128'(a_out_valid), 128'd0);
        applyStimulus(1'b0, 9'h0, 70'h0, 1'b1);
        tick();
        checkOutput("fl_no_ghost", 128'(a_out_valid), 128'd0);
        checkOutput("fl_stall_kept", 128'(a_stall_cnt), 128'd4);

        // Saturation: 2 loads then 18 stall edges on top of 4 -> clamps at 15
        applyStimulus(1'b1, 9'h004, 70'h55, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        checkOutput("sat_stall_cnt", 128'(a_stall_cnt), 128'd15);
        checkOutput("sat_out_data", 128'(a_out_data), 128'h55);

        // Asynchronous reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_out_valid", 128'(a_out_valid), 128'd0);
        checkOutput("areset_out_ctrl", 128'(a_out_ctrl), 128'd0);
        checkOutput("areset_out_data", 128'(a_out_data), 128'd0);
        checkOutput("areset_occupancy", 128'(a_occupancy), 128'd0);
        checkOutput("areset_stall_cnt", 128'(a_stall_cnt), 128'd0);
        applyStimulus(1'b0, 9'h0, 70'h0, 1'b0);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("areset_in_ready", 128'(a_in_ready), 128'd1);

        // SKID=0: combinational ready and same-edge replacement
        tick();
        b_in_valid = 1'b1; b_in_ctrl = 9'h061; b_in_data = 70'h61; b_out_ready = 1'b0;
        tick();
        checkOutput("ns_occ_1", 128'(b_occupancy), 128'd1);
        checkOutput("ns_ready_low", 128'(b_in_ready), 128'd0);
        b_in_ctrl = 9'h062; b_in_data = 70'h62; b_out_ready = 1'b1;
        #1;
        checkOutput("ns_ready_comb", 128'(b_in_ready), 128'd1);
        tick();
        checkOutput("ns_replaced_data", 128'(b_out_data), 128'h62);
        checkOutput("ns_replaced_ctrl", 128'(b_out_ctrl), 128'h062);
        checkOutput("ns_occ_stays_1", 128'(b_occupancy), 128'd1);
        checkOutput("ns_stall_0", 128'(b_stall_cnt), 128'd0);
        b_out_ready = 1'b0;
        tick();
        checkOutput("ns_stall_1", 128'(b_stall_cnt), 128'd1);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        tick();
        checkOutput("ns_drained_valid", 128'(b_out_valid), 128'd0);
        checkOutput("ns_drained_ctrl", 128'(b_out_ctrl), 128'd0);
        checkOutput("ns_drained_occ", 128'(b_occupancy), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
